// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with in-order LSU load results
// into one registered register-file write port, and flags pending-load read hazards.
module wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REGID_W    = 5,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alu_wb_valid,
    input  logic [REGID_W-1:0]              alu_wb_addr,
    input  logic [XLEN-1:0]                 alu_wb_data,
    input  logic                            lsu_wb_valid,
    output logic                            lsu_wb_ready,
    input  logic [REGID_W-1:0]              lsu_wb_addr,
    input  logic [XLEN-1:0]                 lsu_wb_data,
    input  logic [REGID_W-1:0]              rs1_addr,
    input  logic [REGID_W-1:0]              rs2_addr,
    output logic                            rs1_pending,
    output logic                            rs2_pending,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            rd_write,
    output logic [REGID_W-1:0]              rd_addr,
    output logic [XLEN-1:0]                 rd_wdata
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH-1:0] ent_valid_q, ent_valid_d;
    logic [REGID_W-1:0]    ent_addr_q [FIFO_DEPTH];
    logic [XLEN-1:0]       ent_data_q [FIFO_DEPTH];

    logic                  rd_write_q, rd_write_d;
    logic [REGID_W-1:0]    rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]       rd_wdata_q, rd_wdata_d;
    logic                  rd_from_lsu_q, rd_from_lsu_d;

    logic                  full, empty, accept, alu_req, lsu_keep, push, pop;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
    assign empty  = (wr_ptr_q == rd_ptr_q);

    assign lsu_wb_ready = !full && !rst;
    assign accept       = lsu_wb_valid && lsu_wb_ready;
    assign alu_req      = alu_wb_valid && (alu_wb_addr != '0);
    assign lsu_keep     = accept && (lsu_wb_addr != '0);

    // Priority: ALU, then FIFO head, then LSU bypass
    always_comb begin
        push          = 1'b0;
        pop           = 1'b0;
        ent_valid_d   = ent_valid_q;
        rd_write_d    = 1'b0;
        rd_addr_d     = rd_addr_q;
        rd_wdata_d    = rd_wdata_q;
        rd_from_lsu_d = 1'b0;

        if (alu_req) begin
            rd_write_d = 1'b1;
            rd_addr_d  = alu_wb_addr;
            rd_wdata_d = alu_wb_data;
            push       = lsu_keep && (lsu_wb_addr != alu_wb_addr);
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (ent_valid_q[IDX_W'(i)] && (ent_addr_q[IDX_W'(i)] == alu_wb_addr)) begin
                    ent_valid_d[IDX_W'(i)] = 1'b0;
                end
            end
        end else if (!empty) begin
            pop                 = 1'b1;
            push                = lsu_keep;
            ent_valid_d[rd_idx] = 1'b0;
            if (ent_valid_q[rd_idx]) begin
                rd_write_d    = 1'b1;
                rd_addr_d     = ent_addr_q[rd_idx];
                rd_wdata_d    = ent_data_q[rd_idx];
                rd_from_lsu_d = 1'b1;
            end
        end else if (lsu_keep) begin
            rd_write_d    = 1'b1;
            rd_addr_d     = lsu_wb_addr;
            rd_wdata_d    = lsu_wb_data;
            rd_from_lsu_d = 1'b1;
        end

        // The push slot is always free, so it never collides with a kill or pop
        if (push) begin
            ent_valid_d[wr_idx] = 1'b1;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ent_valid_q   <= '0;
            rd_write_q    <= 1'b0;
            rd_addr_q     <= '0;
            rd_wdata_q    <= '0;
            rd_from_lsu_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ent_valid_q   <= ent_valid_d;
            rd_write_q    <= rd_write_d;
            rd_addr_q     <= rd_addr_d;
            rd_wdata_q    <= rd_wdata_d;
            rd_from_lsu_q <= rd_from_lsu_d;
        end
    end

    // Payload storage needs no reset; the valid bits qualify it
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_idx] <= lsu_wb_addr;
            ent_data_q[wr_idx] <= lsu_wb_data;
        end
    end

    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid_q[IDX_W'(i)] && (ent_addr_q[IDX_W'(i)] == rs1_addr)) rs1_pending = 1'b1;
            if (ent_valid_q[IDX_W'(i)] && (ent_addr_q[IDX_W'(i)] == rs2_addr)) rs2_pending = 1'b1;
        end
        if (rd_write_q && rd_from_lsu_q && (rd_addr_q == rs1_addr)) rs1_pending = 1'b1;
        if (rd_write_q && rd_from_lsu_q && (rd_addr_q == rs2_addr)) rs2_pending = 1'b1;
        if (rs1_addr == '0) rs1_pending = 1'b0;
        if (rs2_addr == '0) rs2_pending = 1'b0;
    end

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign rd_write   = rd_write_q;
    assign rd_addr    = rd_addr_q;
    assign rd_wdata   = rd_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_wb_arbiter;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REGID_W = 5;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               alu_wb_valid = 1'b0;
    logic [REGID_W-1:0] alu_wb_addr = '0;
    logic [XLEN-1:0]    alu_wb_data = '0;
    logic               lsu_wb_valid = 1'b0;
    logic               lsu_wb_ready;
    logic [REGID_W-1:0] lsu_wb_addr = '0;
    logic [XLEN-1:0]    lsu_wb_data = '0;
    logic [REGID_W-1:0] rs1_addr = '0;
    logic [REGID_W-1:0] rs2_addr = '0;
    logic               rs1_pending, rs2_pending;
    logic [CNT_W-1:0]   fifo_count;
    logic               rd_write;
    logic [REGID_W-1:0] rd_addr;
    logic [XLEN-1:0]    rd_wdata;

    int checks   = 0;
    int failures = 0;

    wb_arbiter #(.XLEN(XLEN), .REGID_W(REGID_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .fifo_count(fifo_count),
        .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
    );

    always #5 clk = ~clk;

    // Reference model: load queue in acceptance order plus the expected write port
    typedef struct {
        bit                 v;
        logic [REGID_W-1:0] a;
        logic [XLEN-1:0]    d;
    } ent_t;

    ent_t               mq[$];
    bit                 m_wr = 0;
    bit                 m_lsu = 0;
    logic [REGID_W-1:0] m_addr = '0;
    logic [XLEN-1:0]    m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_pending(input logic [REGID_W-1:0] rs);
        bit p = 0;
        if (rs == 0) return 0;
        foreach (mq[i]) if (mq[i].v && mq[i].a == rs) p = 1;
        if (m_wr && m_lsu && m_addr == rs) p = 1;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wr = 0; m_lsu = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_step();
        bit   acc, keep;
        ent_t e;
        acc   = lsu_wb_valid && (mq.size() < DEPTH);
        keep  = acc && (lsu_wb_addr != 0);
        m_wr  = 0;
        m_lsu = 0;
        if (alu_wb_valid && alu_wb_addr != 0) begin
            m_wr = 1; m_addr = alu_wb_addr; m_data = alu_wb_data;
            foreach (mq[i]) begin
                if (mq[i].a == alu_wb_addr) begin
                    e = mq[i]; e.v = 0; mq[i] = e;
                end
            end
            if (keep && lsu_wb_addr != alu_wb_addr) begin
                e.v = 1; e.a = lsu_wb_addr; e.d = lsu_wb_data; mq.push_back(e);
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.v) begin
                m_wr = 1; m_lsu = 1; m_addr = e.a; m_data = e.d;
            end
            if (keep) begin
                e.v = 1; e.a = lsu_wb_addr; e.d = lsu_wb_data; mq.push_back(e);
            end
        end else if (keep) begin
            m_wr = 1; m_lsu = 1; m_addr = lsu_wb_addr; m_data = lsu_wb_data;
        end
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        chk("rd_write",     32'(rd_write),     32'(m_wr));
        chk("rd_addr",      32'(rd_addr),      32'(m_addr));
        chk("rd_wdata",     rd_wdata,          m_data);
        chk("fifo_count",   32'(fifo_count),   32'(mq.size()));
        chk("lsu_wb_ready", 32'(lsu_wb_ready), 32'(!rst && mq.size() < DEPTH));
        chk("rs1_pending",  32'(rs1_pending),  32'(m_pending(rs1_addr)));
        chk("rs2_pending",  32'(rs2_pending),  32'(m_pending(rs2_addr)));
    end

    task automatic cyc(input logic av, input logic [REGID_W-1:0] aa, input logic [XLEN-1:0] ad,
                       input logic lv, input logic [REGID_W-1:0] la, input logic [XLEN-1:0] ld);
        alu_wb_valid = av; alu_wb_addr = aa; alu_wb_data = ad;
        lsu_wb_valid = lv; lsu_wb_addr = la; lsu_wb_data = ld;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_rd_write", 32'(rd_write), 0);
        chk("reset_count",    32'(fifo_count), 0);
        chk("reset_ready",    32'(lsu_wb_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // 1: ALU only
        cyc(1, 5, 32'hDEAD_BEEF, 0, 0, 0);
        chk("t1_write", 32'(rd_write), 1);
        chk("t1_addr",  32'(rd_addr), 5);
        chk("t1_data",  rd_wdata, 32'hDEAD_BEEF);
        idle();
        chk("t1_write_off", 32'(rd_write), 0);
        chk("t1_addr_hold", 32'(rd_addr), 5);

        // 2: LSU bypass with hazard on rs1 for exactly one cycle
        rs1_addr = 3;
        cyc(0, 0, 0, 1, 3, 32'h11);
        chk("t2_write", 32'(rd_write), 1);
        chk("t2_addr",  32'(rd_addr), 3);
        chk("t2_data",  rd_wdata, 32'h11);
        chk("t2_count", 32'(fifo_count), 0);
        chk("t2_pend",  32'(rs1_pending), 1);
        idle();
        chk("t2_pend_off", 32'(rs1_pending), 0);

        // 3: contention, ALU first then LSU
        rs2_addr = 2;
        cyc(1, 1, 32'hA1, 1, 2, 32'hB2);
        chk("t3_alu_addr", 32'(rd_addr), 1);
        chk("t3_count",    32'(fifo_count), 1);
        chk("t3_pend2",    32'(rs2_pending), 1);
        idle();
        chk("t3_lsu_write", 32'(rd_write), 1);
        chk("t3_lsu_addr",  32'(rd_addr), 2);
        chk("t3_lsu_data",  rd_wdata, 32'hB2);
        rs1_addr = 0; rs2_addr = 0;

        // 4: backpressure and in-order retire
        cyc(1, 10, 32'h100, 1, 6, 32'h66);
        cyc(1, 11, 32'h101, 1, 7, 32'h77);
        chk("t4_full_count", 32'(fifo_count), 2);
        chk("t4_not_ready",  32'(lsu_wb_ready), 0);
        cyc(1, 12, 32'h102, 1, 8, 32'h88);
        chk("t4_alu12",   32'(rd_addr), 12);
        chk("t4_count2",  32'(fifo_count), 2);
        cyc(0, 0, 0, 1, 8, 32'h88);
        chk("t4_pop6",    32'(rd_addr), 6);
        chk("t4_data6",   rd_wdata, 32'h66);
        chk("t4_count1",  32'(fifo_count), 1);
        cyc(0, 0, 0, 1, 8, 32'h88);
        chk("t4_pop7",    32'(rd_addr), 7);
        chk("t4_pushpop", 32'(fifo_count), 1);
        idle();
        chk("t4_pop8",    32'(rd_addr), 8);
        chk("t4_data8",   rd_wdata, 32'h88);
        chk("t4_empty",   32'(fifo_count), 0);

        // 5: WAW kill of a queued load
        rs1_addr = 9;
        cyc(1, 13, 32'h1, 1, 9, 32'h99);
        chk("t5_pend_on", 32'(rs1_pending), 1);
        cyc(1, 9, 32'h5, 0, 0, 0);
        chk("t5_alu9",     32'(rd_wdata), 32'h5);
        chk("t5_pend_off", 32'(rs1_pending), 0);
        chk("t5_killed_q", 32'(fifo_count), 1);
        idle();
        chk("t5_kill_bubble", 32'(rd_write), 0);
        chk("t5_drained",     32'(fifo_count), 0);
        rs1_addr = 0;

        // Same-cycle kill, LSU x0 drop, ALU x0 ignored
        cyc(1, 14, 32'hE, 1, 14, 32'hF);
        chk("kill_same_count", 32'(fifo_count), 0);
        idle();
        chk("kill_same_nowr", 32'(rd_write), 0);
        cyc(0, 0, 0, 1, 0, 32'h77);
        chk("lsu_x0_nowr", 32'(rd_write), 0);
        cyc(1, 0, 32'h55, 0, 0, 0);
        chk("alu_x0_nowr", 32'(rd_write), 0);

        // 6: reset with two entries queued
        cyc(1, 15, 32'h15, 1, 16, 32'h161);
        cyc(1, 17, 32'h17, 1, 18, 32'h181);
        chk("t6_pre_count", 32'(fifo_count), 2);
        idle();
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_write", 32'(rd_write), 0);
        chk("t6_rst_count", 32'(fifo_count), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) idle();
        chk("t6_no_replay", 32'(rd_write), 0);
        chk("t6_empty",     32'(fifo_count), 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
